mul4b_seq_ctrl: RTL

Sequencing controller that computes an unsigned 4x4 -> 8-bit product by reusing a single `bloque_mul4b` multiplier row over four clock cycles, instead of the four cascaded rows of a full array multiplier. It latches the operands on a start request and feeds the row one multiplier bit per cycle. Between cycles it registers the row's partial sum and carry, shifts out finished low-order product bits, and raises a one-cycle done pulse with the final product. It sits between a requesting host (register file or FSM) and the shared `bloque_mul4b` datapath row, which it instantiates internally.

---
 rtl/mul4b_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mul4b_seq_ctrl.sv
// Sequential 4x4 unsigned multiplier. One shared bloque_mul4b row is reused
// over four cycles, consuming one multiplier bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; P holds the last product
// RUN   | row evaluated for cnt=0..3, partial sum and low bits registered
// DONE  | one-cycle done pulse, P valid

module bloque_mul4b (
    input  logic [3:0] X,
    input  logic       Y,
    input  logic [2:0] Sx,
    input  logic       Si,
    output logic [3:0] So,
    output logic       Co
);
    logic [3:0] w_pp;
    logic [4:0] w_c;

    assign w_pp   = X & {4{Y}};
    assign w_c[0] = 1'b0;

    // Ripple of full adders: incoming partial sum {Si, Sx} plus X gated by Y
    always_comb begin
        So = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                So[i] = Sx[i] ^ w_pp[i] ^ w_c[i];
            end else begin
                So[i] = Si ^ w_pp[i] ^ w_c[i];
            end
        end
    end

    assign w_c[1] = (Sx[0] & w_pp[0]) | (w_c[0] & (Sx[0] ^ w_pp[0]));
    assign w_c[2] = (Sx[1] & w_pp[1]) | (w_c[1] & (Sx[1] ^ w_pp[1]));
    assign w_c[3] = (Sx[2] & w_pp[2]) | (w_c[2] & (Sx[2] ^ w_pp[2]));
    assign w_c[4] = (Si    & w_pp[3]) | (w_c[3] & (Si    ^ w_pp[3]));
    assign Co     = w_c[4];
endmodule

module mul4b_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [7:0] P
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_hi;
    logic [3:0] r_lo;
    logic [1:0] r_cnt;
    logic [7:0] r_p;
    logic       w_load;
    logic       w_y;
    logic [3:0] w_so;
    logic       w_co;

    assign w_y = r_b[r_cnt];

    bloque_mul4b u_row (
        .X  (r_a),
        .Y  (w_y),
        .Sx (r_hi[2:0]),
        .Si (r_hi[3]),
        .So (w_so),
        .Co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The DONE exit edge doubles as the earliest accept point, so a held
    // start re-triggers every 5 cycles; start seen during RUN is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == 2'd3) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_hi  <= {w_co, w_so[3:1]};
            r_lo  <= {w_so[0], r_lo[3:1]};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_p <= {w_co, w_so[3:1], w_so[0], r_lo[3:1]};
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign P    = r_p;
endmodule
